// File: rtl/wb_gpio_irq.sv
// Wishbone classic GPIO slave: pad output/enable registers, synchronized inputs,
// per-pin rise/fall edge detection latched into a W1C STATUS feeding a level irq.

module wb_gpio_irq_lane (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  input  logic rise_en_i,
  input  logic fall_en_i,
  input  logic clr_i,
  output logic sync_o,
  output logic status_o
);
  logic s1_q, s2_q, prev_q, st_q, st_d, set;

  assign set      = (s2_q & ~prev_q & rise_en_i) | (~s2_q & prev_q & fall_en_i);
  // A new edge in the same cycle as a W1C keeps the bit set.
  assign st_d     = (st_q & ~clr_i) | set;
  assign sync_o   = s2_q;
  assign status_o = st_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      st_q   <= 1'b0;
    end else begin
      s1_q   <= pin_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      st_q   <= st_d;
    end
  end
endmodule

module wb_gpio_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
  parameter int          NUM_IO    = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [NUM_IO-1:0] gpio_in_i,
  output logic [NUM_IO-1:0] gpio_out_o,
  output logic [NUM_IO-1:0] gpio_oeb_o,
  output logic              irq_o
);
  localparam logic [5:0] R_OUT = 6'h0, R_OEB = 6'h1, R_IN = 6'h2,
                         R_RISE = 6'h3, R_FALL = 6'h4, R_STAT = 6'h5;

  logic              ack_q, irq_q;
  logic [31:0]       dat_q, dat_d;
  logic [NUM_IO-1:0] out_q, out_d, oeb_q, oeb_d, rise_q, rise_d, fall_q, fall_d;
  logic [NUM_IO-1:0] sync, status, clr, wm_io, wd_io;
  logic [31:0]       wmask;
  logic [5:0]        reg_sel;
  logic              hit, commit, wr;

  assign hit     = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign commit  = hit & ~ack_q;
  assign wr      = commit & wbs_we_i;
  assign reg_sel = wbs_adr_i[7:2];
  assign wmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wm_io   = wmask[NUM_IO-1:0];
  assign wd_io   = wbs_dat_i[NUM_IO-1:0];
  assign clr     = (wr && reg_sel == R_STAT) ? (wd_io & wm_io) : '0;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_lane
    wb_gpio_irq_lane u_lane (
      .clk_i     (wb_clk_i),
      .rst_ni    (wb_rst_ni),
      .pin_i     (gpio_in_i[i]),
      .rise_en_i (rise_q[i]),
      .fall_en_i (fall_q[i]),
      .clr_i     (clr[i]),
      .sync_o    (sync[i]),
      .status_o  (status[i])
    );
  end

  always_comb begin
    out_d  = out_q;
    oeb_d  = oeb_q;
    rise_d = rise_q;
    fall_d = fall_q;
    dat_d  = '0;
    if (wr) begin
      case (reg_sel)
        R_OUT:   out_d  = (out_q  & ~wm_io) | (wd_io & wm_io);
        R_OEB:   oeb_d  = (oeb_q  & ~wm_io) | (wd_io & wm_io);
        R_RISE:  rise_d = (rise_q & ~wm_io) | (wd_io & wm_io);
        R_FALL:  fall_d = (fall_q & ~wm_io) | (wd_io & wm_io);
        default: ;
      endcase
    end
    // Read data is only non-zero in the ack cycle.
    if (commit && !wbs_we_i) begin
      case (reg_sel)
        R_OUT:   dat_d = 32'(out_q);
        R_OEB:   dat_d = 32'(oeb_q);
        R_IN:    dat_d = 32'(sync);
        R_RISE:  dat_d = 32'(rise_q);
        R_FALL:  dat_d = 32'(fall_q);
        R_STAT:  dat_d = 32'(status);
        default: dat_d = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      ack_q  <= 1'b0;
      dat_q  <= '0;
      out_q  <= '0;
      oeb_q  <= '1;
      rise_q <= '0;
      fall_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ack_q  <= commit;
      dat_q  <= dat_d;
      out_q  <= out_d;
      oeb_q  <= oeb_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      irq_q  <= |status;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign gpio_out_o = out_q;
  assign gpio_oeb_o = oeb_q;
  assign irq_o      = irq_q;
endmodule

// File: tb/tb_wb_gpio_irq.sv
// Self-checking bench for wb_gpio_irq: vector table, directed corner sequences,
// and randomized traffic checked every cycle against a register-level model.

module tb_wb_gpio_irq;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_FF00;

  logic        wb_clk_i = 1'b0, wb_rst_ni = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, wdat = '0, gpio_in = '0;
  logic        wbs_ack_o, irq_o;
  logic [31:0] wbs_dat_o, gpio_out_o, gpio_oeb_o;

  int n_cmp = 0, n_err = 0;
  bit chk_en = 1'b0;

  wb_gpio_irq dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .gpio_in_i(gpio_in), .gpio_out_o(gpio_out_o), .gpio_oeb_o(gpio_oeb_o), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: registers as plain words, pad history as the last three sampled values.
  logic [31:0] m_out, m_oeb, m_rise, m_fall, m_st, m_dat;
  logic [31:0] h0, h1, h2;   // pin value sampled 1, 2, 3 edges ago
  logic        m_ack, m_irq;

  function automatic logic [31:0] bmask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction
  function automatic logic m_commit();
    return cyc && stb && ((adr & MASK) == BASE) && !m_ack;
  endfunction
  function automatic logic [31:0] upd(input logic [31:0] old);
    return (old & ~bmask(sel)) | (wdat & bmask(sel));
  endfunction
  function automatic logic [31:0] m_read(input logic [5:0] off);
    case (off)
      6'd0: return m_out;
      6'd1: return m_oeb;
      6'd2: return h1;
      6'd3: return m_rise;
      6'd4: return m_fall;
      6'd5: return m_st;
      default: return 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] m_set();
    return (h1 & ~h2 & m_rise) | (~h1 & h2 & m_fall);
  endfunction
  function automatic logic [31:0] m_clr();
    return (m_commit() && we && adr[7:2] == 6'd5) ? (wdat & bmask(sel)) : 32'h0;
  endfunction

  always @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      m_out <= '0; m_oeb <= '1; m_rise <= '0; m_fall <= '0; m_st <= '0;
      m_dat <= '0; m_ack <= 1'b0; m_irq <= 1'b0;
      h0 <= '0; h1 <= '0; h2 <= '0;
    end else begin
      m_st  <= (m_st & ~m_clr()) | m_set();
      m_irq <= (m_st != 0);
      m_ack <= m_commit();
      m_dat <= (m_commit() && !we) ? m_read(adr[7:2]) : 32'h0;
      if (m_commit() && we) begin
        case (adr[7:2])
          6'd0: m_out  <= upd(m_out);
          6'd1: m_oeb  <= upd(m_oeb);
          6'd3: m_rise <= upd(m_rise);
          6'd4: m_fall <= upd(m_fall);
          default: ;
        endcase
      end
      h0 <= gpio_in; h1 <= h0; h2 <= h1;
    end
  end

  always @(negedge wb_clk_i) begin
    if (chk_en) begin
      check("mdl_ack", 32'(wbs_ack_o), 32'(m_ack));
      check("mdl_dat", wbs_dat_o, m_dat);
      check("mdl_out", gpio_out_o, m_out);
      check("mdl_oeb", gpio_oeb_o, m_oeb);
      check("mdl_irq", 32'(irq_o), 32'(m_irq));
    end
  end

  // Starts driving at the current time (a negedge); returns at the negedge of the ack cycle.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] s,
                      input logic [31:0] d, output logic [31:0] rd, output logic got);
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    got = 1'b0; rd = '0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(posedge wb_clk_i); @(negedge wb_clk_i);
      if (wbs_ack_o) begin got = 1'b1; rd = wbs_dat_o; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge wb_clk_i); @(negedge wb_clk_i); end
  endtask

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic        w;
    logic [3:0]  s;
    logic [31:0] d;
    logic        exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[$];
  logic [31:0] rd;
  logic        got;

  initial begin
    vt.push_back('{"rst_oeb",   BASE+32'h04, 1'b0, 4'hF, 32'h0,          1'b1, 32'hFFFF_FFFF});
    vt.push_back('{"rst_out",   BASE+32'h00, 1'b0, 4'hF, 32'h0,          1'b1, 32'h0});
    vt.push_back('{"rst_stat",  BASE+32'h14, 1'b0, 4'hF, 32'h0,          1'b1, 32'h0});
    vt.push_back('{"wr_out",    BASE+32'h00, 1'b1, 4'b0101, 32'hA5A5_5A5A, 1'b1, 32'h0});
    vt.push_back('{"rd_out",    BASE+32'h03, 1'b0, 4'hF, 32'h0,          1'b1, 32'h00A5_005A});
    vt.push_back('{"wr_oeb",    BASE+32'h04, 1'b1, 4'b1100, 32'h1234_0000, 1'b1, 32'h0});
    vt.push_back('{"rd_oeb",    BASE+32'h04, 1'b0, 4'hF, 32'h0,          1'b1, 32'h1234_FFFF});
    vt.push_back('{"wr_in",     BASE+32'h08, 1'b1, 4'hF, 32'hFFFF_FFFF,  1'b1, 32'h0});
    vt.push_back('{"rd_in",     BASE+32'h08, 1'b0, 4'hF, 32'h0,          1'b1, 32'h0});
    vt.push_back('{"wr_hole",   BASE+32'h40, 1'b1, 4'hF, 32'hDEAD_BEEF,  1'b1, 32'h0});
    vt.push_back('{"rd_hole",   BASE+32'h40, 1'b0, 4'hF, 32'h0,          1'b1, 32'h0});
    vt.push_back('{"miss",      BASE+32'h100, 1'b0, 4'hF, 32'h0,         1'b0, 32'h0});
    vt.push_back('{"wr_oeb2",   BASE+32'h04, 1'b1, 4'hF, 32'hFFFF_0000,  1'b1, 32'h0});
    vt.push_back('{"rd_oeb2",   BASE+32'h04, 1'b0, 4'hF, 32'h0,          1'b1, 32'hFFFF_0000});

    wait_cyc(2);
    wb_rst_ni = 1'b1;
    chk_en = 1'b1;
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_oeb_pins", gpio_oeb_o, 32'hFFFF_FFFF);
    check("rst_out_pins", gpio_out_o, 32'h0);

    foreach (vt[i]) begin
      xfer(vt[i].a, vt[i].w, vt[i].s, vt[i].d, rd, got);
      check({vt[i].nm, "_ack"}, 32'(got), 32'(vt[i].exp_ack));
      if (vt[i].exp_ack && !vt[i].w) check({vt[i].nm, "_rd"}, rd, vt[i].exp_rd);
      if (vt[i].a == BASE && vt[i].w) begin
        @(posedge wb_clk_i); @(negedge wb_clk_i);
        check("out_pins", gpio_out_o, 32'h00A5_005A);
      end
    end

    // Rising edge on pin 0: status after 3 edges, irq one edge later.
    xfer(BASE+32'h0C, 1'b1, 4'hF, 32'h1, rd, got);
    gpio_in[0] = 1'b1;
    wait_cyc(3);
    check("rise_irq_early", 32'(irq_o), 32'h0);
    wait_cyc(1);
    check("rise_irq", 32'(irq_o), 32'h1);
    xfer(BASE+32'h14, 1'b0, 4'hF, 32'h0, rd, got);
    check("rise_stat", rd, 32'h1);
    xfer(BASE+32'h14, 1'b1, 4'hF, 32'h1, rd, got);
    wait_cyc(1);
    check("w1c_irq", 32'(irq_o), 32'h0);
    gpio_in[0] = 1'b0;
    wait_cyc(6);
    check("fall_noen_irq", 32'(irq_o), 32'h0);
    xfer(BASE+32'h14, 1'b0, 4'hF, 32'h0, rd, got);
    check("fall_noen_stat", rd, 32'h0);

    // Falling edge on pin 5 landing on the same edge as a W1C of bit 5.
    xfer(BASE+32'h10, 1'b1, 4'hF, 32'h20, rd, got);
    gpio_in[5] = 1'b1;
    wait_cyc(6);
    gpio_in[5] = 1'b0;
    wait_cyc(5);
    check("fall_irq", 32'(irq_o), 32'h1);
    gpio_in[5] = 1'b1;
    wait_cyc(6);
    gpio_in[5] = 1'b0;
    wait_cyc(2);
    xfer(BASE+32'h14, 1'b1, 4'hF, 32'h20, rd, got);
    check("race_ack", 32'(got), 32'h1);
    wait_cyc(1);
    check("race_irq", 32'(irq_o), 32'h1);
    xfer(BASE+32'h14, 1'b0, 4'hF, 32'h0, rd, got);
    check("race_stat", rd, 32'h20);

    // Reset lands on the edge that would have committed a write.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = BASE; wdat = 32'h1234_5678;
    wb_rst_ni = 1'b0;
    @(posedge wb_clk_i); @(negedge wb_clk_i);
    check("rstwr_ack", 32'(wbs_ack_o), 32'h0);
    wb_rst_ni = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    xfer(BASE, 1'b0, 4'hF, 32'h0, rd, got);
    check("rstwr_out", rd, 32'h0);
    xfer(BASE, 1'b1, 4'hF, 32'hCAFE_F00D, rd, got);
    check("retry_ack", 32'(got), 32'h1);
    xfer(BASE, 1'b0, 4'hF, 32'h0, rd, got);
    check("retry_out", rd, 32'hCAFE_F00D);

    // Randomized traffic; the per-cycle model comparison does the checking.
    xfer(BASE+32'h0C, 1'b1, 4'hF, $urandom, rd, got);
    xfer(BASE+32'h10, 1'b1, 4'hF, $urandom, rd, got);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      gpio_in = gpio_in ^ ($urandom & $urandom & $urandom);
      a = BASE + {24'h0, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom)};
      if ($urandom_range(0, 15) == 0) a = a + 32'h100;
      if ($urandom_range(0, 15) == 0) a = a + 32'h40;
      if ($urandom_range(0, 19) == 0) begin
        xfer(a, 1'($urandom), 4'($urandom), $urandom, rd, got);
      end else begin
        xfer(a & ~32'h100, 1'($urandom), 4'($urandom), $urandom, rd, got);
      end
      if ($urandom_range(0, 3) == 0) wait_cyc($urandom_range(1, 4));
    end
    wait_cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
